// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use / multi-cycle stall detection, stall counter.
// Latency: forwarding and stall are combinational (0 cycles); mc_busy asserts the cycle after issue for MC_LAT cycles.
// Backpressure: stall holds PC and IF/ID and bubbles EX; a multi-cycle issue is accepted only when stall is low.
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int N_SRC  = 2,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC*REG_AW-1:0]  ex_src,
    input  logic [N_SRC*REG_AW-1:0]  id_src,
    input  logic [N_SRC-1:0]         id_src_valid,
    input  logic                     ex_mem_read,
    input  logic [REG_AW-1:0]        ex_wr,
    input  logic                     m_reg_write,
    input  logic [REG_AW-1:0]        m_wr,
    input  logic                     wb_reg_write,
    input  logic [REG_AW-1:0]        wb_wr,
    input  logic                     mc_issue,
    input  logic [REG_AW-1:0]        mc_wr,
    output logic [N_SRC-1:0]         en_f,
    output logic [N_SRC-1:0]         sel_f,
    output logic                     stall,
    output logic [1:0]               stall_cause,
    output logic                     mc_busy,
    output logic                     mc_done,
    output logic [CNT_W-1:0]         stall_cnt
);

    // MC_LAT is at most 15, so the countdown fits in 4 bits.
    localparam int CD_W = 4;

    logic [CD_W-1:0]   countdown;
    logic [REG_AW-1:0] mc_dest;
    logic              lu_hz;
    logic              raw_hz;
    logic              st_hz;
    logic              done_raw;
    logic              accept;

    // Final busy cycle, before the reset override.
    assign done_raw = mc_busy && (countdown == '0);

    // Per-slot forwarding select: M stage wins over WB; register 0 never forwards.
    always_comb begin
        en_f  = '0;
        sel_f = '0;
        if (!rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (m_reg_write && (m_wr != '0) && (m_wr == ex_src[i*REG_AW +: REG_AW])) begin
                    en_f[i]  = 1'b1;
                    sel_f[i] = 1'b0;
                end else if (wb_reg_write && (wb_wr != '0) &&
                             (wb_wr == ex_src[i*REG_AW +: REG_AW])) begin
                    en_f[i]  = 1'b1;
                    sel_f[i] = 1'b1;
                end
            end
        end
    end

    // Hazard detection against the ID-stage operands that are actually read.
    always_comb begin
        lu_hz  = 1'b0;
        raw_hz = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (id_src_valid[i]) begin
                if (ex_mem_read && (ex_wr != '0) && (ex_wr == id_src[i*REG_AW +: REG_AW]))
                    lu_hz = 1'b1;
                if (mc_busy && (mc_dest != '0) && (mc_dest == id_src[i*REG_AW +: REG_AW]))
                    raw_hz = 1'b1;
            end
        end
        // In the done cycle the unit frees up, so a new issue is not structurally blocked.
        st_hz = mc_issue && mc_busy && !done_raw;
    end

    // Stall output and prioritised cause (LU > RAW > ST), all forced low in reset.
    always_comb begin
        stall       = 1'b0;
        stall_cause = 2'b00;
        mc_done     = 1'b0;
        if (!rst) begin
            stall   = lu_hz || raw_hz || st_hz;
            mc_done = done_raw;
            if (lu_hz)
                stall_cause = 2'b01;
            else if (raw_hz)
                stall_cause = 2'b10;
            else if (st_hz)
                stall_cause = 2'b11;
        end
    end

    assign accept = mc_issue && !stall && !rst;

    // Multi-cycle unit occupancy: issue loads the countdown; an issue in the done cycle reloads with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_busy   <= 1'b0;
            mc_dest   <= '0;
            countdown <= '0;
        end else if (accept) begin
            mc_busy   <= 1'b1;
            mc_dest   <= mc_wr;
            countdown <= CD_W'(MC_LAT - 1);
        end else if (mc_busy) begin
            if (countdown == '0)
                mc_busy <= 1'b0;
            else
                countdown <= countdown - CD_W'(1);
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding/load-use vector table plus multi-cycle sequences.
// Inputs are driven just after the falling edge and outputs sampled 1 ns later.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_hazard_fwd_unit;

    logic        clk;
    logic        rst;
    logic [9:0]  ex_src;
    logic [9:0]  id_src;
    logic [1:0]  id_src_valid;
    logic        ex_mem_read;
    logic [4:0]  ex_wr;
    logic        m_reg_write;
    logic [4:0]  m_wr;
    logic        wb_reg_write;
    logic [4:0]  wb_wr;
    logic        mc_issue;
    logic [4:0]  mc_wr;

    logic [1:0]  en_f, sel_f, stall_cause;
    logic        stall, mc_busy, mc_done;
    logic [15:0] stall_cnt;

    logic [1:0]  en_f2, sel_f2, stall_cause2;
    logic        stall2, mc_busy2, mc_done2;
    logic [1:0]  stall_cnt2;

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt;
    int exp_cnt2;

    hazard_fwd_unit #(.REG_AW(5), .N_SRC(2), .MC_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ex_src(ex_src), .id_src(id_src), .id_src_valid(id_src_valid),
        .ex_mem_read(ex_mem_read), .ex_wr(ex_wr), .m_reg_write(m_reg_write), .m_wr(m_wr),
        .wb_reg_write(wb_reg_write), .wb_wr(wb_wr), .mc_issue(mc_issue), .mc_wr(mc_wr),
        .en_f(en_f), .sel_f(sel_f), .stall(stall), .stall_cause(stall_cause),
        .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt)
    );

    hazard_fwd_unit #(.REG_AW(5), .N_SRC(2), .MC_LAT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .ex_src(ex_src), .id_src(id_src), .id_src_valid(id_src_valid),
        .ex_mem_read(ex_mem_read), .ex_wr(ex_wr), .m_reg_write(m_reg_write), .m_wr(m_wr),
        .wb_reg_write(wb_reg_write), .wb_wr(wb_wr), .mc_issue(mc_issue), .mc_wr(mc_wr),
        .en_f(en_f2), .sel_f(sel_f2), .stall(stall2), .stall_cause(stall_cause2),
        .mc_busy(mc_busy2), .mc_done(mc_done2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ex0, ex1, id0, id1;
        logic [1:0] idv;
        logic       exmr;
        logic [4:0] exwr;
        logic       mrw;
        logic [4:0] mwr;
        logic       wrw;
        logic [4:0] wwr;
        logic [1:0] en, sel;
        logic       st;
        logic [1:0] cause;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    endtask

    task automatic idle();
        ex_src = '0; id_src = '0; id_src_valid = '0;
        ex_mem_read = 1'b0; ex_wr = '0;
        m_reg_write = 1'b0; m_wr = '0;
        wb_reg_write = 1'b0; wb_wr = '0;
        mc_issue = 1'b0; mc_wr = '0;
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //            ex0  ex1  id0   id1  idv    exmr exwr  mrw  mwr  wrw  wwr  en     sel    st  cause
        vt[0]  = '{5'd5, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd5, 2'b11, 2'b00, 1'b0, 2'b00};
        vt[1]  = '{5'd5, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 2'b11, 2'b11, 1'b0, 2'b00};
        vt[2]  = '{5'd3, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd7, 2'b11, 2'b10, 1'b0, 2'b00};
        vt[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 2'b00, 2'b00, 1'b0, 2'b00};
        vt[4]  = '{5'd4, 5'd2, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 2'b01, 2'b00, 1'b0, 2'b00};
        vt[5]  = '{5'd0, 5'd0, 5'd1, 5'd8, 2'b10, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b1, 2'b01};
        vt[6]  = '{5'd0, 5'd0, 5'd1, 5'd8, 2'b00, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0, 2'b00};
        vt[7]  = '{5'd0, 5'd0, 5'd1, 5'd8, 2'b01, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0, 2'b00};
        vt[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0, 2'b00};
        vt[9]  = '{5'd0, 5'd0, 5'd0, 5'd8, 2'b10, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0, 2'b00};
        vt[10] = '{5'd0, 5'd0, 5'd12, 5'd3, 2'b01, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b1, 2'b01};
        vt[11] = '{5'd9, 5'd6, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd9, 2'b01, 2'b01, 1'b0, 2'b00};

        // Reset with live hazards on the inputs: every combinational output must be held low.
        idle();
        rst = 1'b1;
        m_reg_write = 1'b1; m_wr = 5'd5; ex_src = {5'd5, 5'd5};
        ex_mem_read = 1'b1; ex_wr = 5'd8; id_src = {5'd8, 5'd0}; id_src_valid = 2'b10;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_en_f", 32'(en_f), 32'd0);
        chk("rst_sel_f", 32'(sel_f), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_cause", 32'(stall_cause), 32'd0);
        chk("rst_busy", 32'(mc_busy), 32'd0);
        chk("rst_done", 32'(mc_done), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt  = 0;
        exp_cnt2 = 0;

        // Combinational forwarding / load-use table.
        for (int i = 0; i < 12; i++) begin
            ex_src = {vt[i].ex1, vt[i].ex0};
            id_src = {vt[i].id1, vt[i].id0};
            id_src_valid = vt[i].idv;
            ex_mem_read = vt[i].exmr; ex_wr = vt[i].exwr;
            m_reg_write = vt[i].mrw; m_wr = vt[i].mwr;
            wb_reg_write = vt[i].wrw; wb_wr = vt[i].wwr;
            #1;
            chk($sformatf("vec%0d_en_f", i), 32'(en_f), 32'(vt[i].en));
            chk($sformatf("vec%0d_sel_f", i), 32'(sel_f), 32'(vt[i].sel));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].st));
            chk($sformatf("vec%0d_cause", i), 32'(stall_cause), 32'(vt[i].cause));
            chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt), 32'(exp_cnt));
            chk($sformatf("vec%0d_cnt2", i), 32'(stall_cnt2), 32'(exp_cnt2));
            if (vt[i].st) begin
                exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
            @(negedge clk);
        end

        // Five more load-use stalls: the wide counter keeps counting, the 2-bit one holds at 3.
        idle();
        ex_mem_read = 1'b1; ex_wr = 5'd8; id_src = {5'd8, 5'd0}; id_src_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("sat%0d_stall", k), 32'(stall), 32'd1);
            @(negedge clk);
        end
        idle();
        #1;
        chk("sat_cnt16", 32'(stall_cnt), 32'd7);
        chk("sat_cnt2", 32'(stall_cnt2), 32'd3);
        chk("sat_idle_stall", 32'(stall), 32'd0);
        @(negedge clk);

        // Multi-cycle RAW: issue dest 9, ID reads r9 while busy; a load-use at t+2 takes priority.
        pulse_reset();
        mc_issue = 1'b1; mc_wr = 5'd9; id_src = {5'd0, 5'd9}; id_src_valid = 2'b01;
        #1;
        chk("raw_t0_stall", 32'(stall), 32'd0);
        chk("raw_t0_busy", 32'(mc_busy), 32'd0);
        @(negedge clk);
        mc_issue = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            ex_mem_read = (k == 2);
            ex_wr = 5'd9;
            #1;
            chk($sformatf("raw_t%0d_busy", k), 32'(mc_busy), 32'd1);
            chk($sformatf("raw_t%0d_stall", k), 32'(stall), 32'd1);
            chk($sformatf("raw_t%0d_cause", k), 32'(stall_cause), (k == 2) ? 32'd1 : 32'd2);
            chk($sformatf("raw_t%0d_done", k), 32'(mc_done), (k == 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        #1;
        chk("raw_t5_busy", 32'(mc_busy), 32'd0);
        chk("raw_t5_stall", 32'(stall), 32'd0);
        chk("raw_t5_cause", 32'(stall_cause), 32'd0);
        chk("raw_t5_done", 32'(mc_done), 32'd0);
        chk("raw_t5_cnt", 32'(stall_cnt), 32'd4);
        @(negedge clk);

        // Structural stall, then back-to-back issue accepted in the done cycle.
        pulse_reset();
        mc_issue = 1'b1; mc_wr = 5'd9;
        #1;
        chk("st_t0_stall", 32'(stall), 32'd0);
        @(negedge clk);
        mc_wr = 5'd10;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk($sformatf("st_t%0d_busy", k), 32'(mc_busy), 32'd1);
            chk($sformatf("st_t%0d_stall", k), 32'(stall), 32'd1);
            chk($sformatf("st_t%0d_cause", k), 32'(stall_cause), 32'd3);
            chk($sformatf("st_t%0d_done", k), 32'(mc_done), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("st_t4_done", 32'(mc_done), 32'd1);
        chk("st_t4_stall", 32'(stall), 32'd0);
        chk("st_t4_busy", 32'(mc_busy), 32'd1);
        @(negedge clk);
        mc_issue = 1'b0; id_src = {5'd0, 5'd10}; id_src_valid = 2'b01;
        for (int k = 5; k <= 8; k++) begin
            #1;
            chk($sformatf("b2b_t%0d_busy", k), 32'(mc_busy), 32'd1);
            chk($sformatf("b2b_t%0d_cause", k), 32'(stall_cause), 32'd2);
            chk($sformatf("b2b_t%0d_done", k), 32'(mc_done), (k == 8) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        #1;
        chk("b2b_t9_busy", 32'(mc_busy), 32'd0);
        chk("b2b_t9_stall", 32'(stall), 32'd0);
        chk("b2b_t9_cnt", 32'(stall_cnt), 32'd7);
        @(negedge clk);

        // Reset in the middle of an operation abandons it; the next issue starts afresh.
        pulse_reset();
        mc_issue = 1'b1; mc_wr = 5'd9; id_src = {5'd0, 5'd9}; id_src_valid = 2'b01;
        #1;
        @(negedge clk);
        mc_issue = 1'b0;
        #1;
        chk("mrst_t1_stall", 32'(stall), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_t2_cnt", 32'(stall_cnt), 32'd1);
        chk("mrst_t2_stall", 32'(stall), 32'd0);
        chk("mrst_t2_done", 32'(mc_done), 32'd0);
        chk("mrst_t2_busy", 32'(mc_busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            #1;
            chk($sformatf("mrst_t%0d_busy", k), 32'(mc_busy), 32'd0);
            chk($sformatf("mrst_t%0d_done", k), 32'(mc_done), 32'd0);
            chk($sformatf("mrst_t%0d_cnt", k), 32'(stall_cnt), 32'd0);
            @(negedge clk);
        end
        id_src_valid = 2'b00;
        mc_issue = 1'b1;
        #1;
        chk("post_t0_stall", 32'(stall), 32'd0);
        @(negedge clk);
        mc_issue = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("post_t%0d_busy", k), 32'(mc_busy), 32'd1);
            chk($sformatf("post_t%0d_done", k), 32'(mc_done), (k == 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        #1;
        chk("post_t5_busy", 32'(mc_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
  REG_AW  5  register-address width
  N_SRC  2  source operands per instruction
  MC_LAT  4  multi-cycle unit latency in cycles, legal range 2..15
  CNT_W  16  stall-counter width
REQ-002 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  ex_src  in  N_SRC*REG_AW  EX-stage source register numbers; slot i is bits [i*REG_AW +: REG_AW]
  id_src  in  N_SRC*REG_AW  ID-stage source register numbers, same packing
  id_src_valid  in  N_SRC  ID source slot i is actually read
  ex_mem_read  in  1  EX instruction is a load
  ex_wr  in  REG_AW  EX destination register
  m_reg_write  in  1  M-stage instruction writes a register
  m_wr  in  REG_AW  M destination register
  wb_reg_write  in  1  WB-stage instruction writes a register
  wb_wr  in  REG_AW  WB destination register
  mc_issue  in  1  ID instruction is a multi-cycle op requesting issue
  mc_wr  in  REG_AW  destination of the issuing multi-cycle op
  en_f  out  N_SRC  forwarding enable per EX source
  sel_f  out  N_SRC  forwarding source per EX source: 0 = M, 1 = WB
  stall  out  1  hold PC and IF/ID; bubble into EX
  stall_cause  out  2  00 none, 01 load-use, 10 multi-cycle RAW, 11 multi-cycle structural
  mc_busy  out  1  multi-cycle unit occupied
  mc_done  out  1  one-cycle pulse in the final busy cycle
  stall_cnt  out  CNT_W  saturating count of stalled cycles

Function
REQ-004 For each slot i, the block SHALL drive en_f[i]=1 and sel_f[i]=0 when m_reg_write, m_wr!=0 and m_wr==ex_src slot i.
REQ-005 Otherwise, the block SHALL drive en_f[i]=1 and sel_f[i]=1 when wb_reg_write, wb_wr!=0 and wb_wr==ex_src slot i.
REQ-006 Otherwise, the block SHALL drive en_f[i]=0 and sel_f[i]=0.
REQ-007 Forwarding SHALL be combinational, with zero latency and M taking priority over WB.
REQ-008 The block SHALL raise load-use hazard (LU) when ex_mem_read, ex_wr!=0, and ex_wr equals some id_src slot whose id_src_valid bit is 1.
REQ-009 The block SHALL hold an internal register mc_dest (REG_AW bits), loaded with mc_wr on an accepted issue.
REQ-010 The block SHALL raise multi-cycle RAW hazard (RAW) when mc_busy, mc_dest!=0, and mc_dest equals some valid id_src slot.
REQ-011 The block SHALL raise multi-cycle structural hazard (ST) when mc_issue and mc_busy are both 1 and mc_done is 0.
REQ-012 stall SHALL equal LU|RAW|ST, combinationally.
REQ-013 stall_cause SHALL encode the highest-priority active hazard, priority LU > RAW > ST; it SHALL be 00 when stall=0.
REQ-014 An issue SHALL be accepted only in a cycle where mc_issue=1 and stall=0.
REQ-015 On an accepted issue, an internal countdown SHALL load MC_LAT-1 and mc_busy SHALL be 1 for exactly MC_LAT cycles, starting the next cycle.
REQ-016 mc_done SHALL be 1 only when mc_busy=1 and countdown==0; in that cycle RAW SHALL still apply, and ST SHALL not apply.
REQ-017 Back-to-back issue: an issue accepted in the mc_done cycle SHALL reload the countdown, so mc_busy stays 1 with no gap.
REQ-018 stall_cnt SHALL increment by 1 on every rising clk edge with stall=1, and SHALL saturate at 2^CNT_W-1.
REQ-019 Register 0 SHALL never cause forwarding or a stall.

Reset
REQ-020 While rst=1, at each rising edge the block SHALL clear mc_busy, mc_dest, the countdown and stall_cnt to 0.
REQ-021 While rst=1, en_f, sel_f, stall, stall_cause and mc_done SHALL be forced to 0.
REQ-022 A reset during multi-cycle operation SHALL abandon the operation, with no mc_done pulse.
REQ-023 The first accepted issue after rst deasserts SHALL behave as from power-up.

Verification
REQ-024 Scenario: m_reg_write=1, m_wr=5, wb_reg_write=1, wb_wr=5, ex_src={5,5} -> en_f=11, sel_f=00; then m_reg_write=0 -> en_f=11, sel_f=11.
REQ-025 Scenario: ex_mem_read=1, ex_wr=8, id_src slot1=8, id_src_valid=10 -> stall=1, stall_cause=01 for that cycle, and stall_cnt increments by 1; with id_src_valid=00 -> stall=0.
REQ-026 Scenario: mc_issue=1, mc_wr=9, MC_LAT=4 at cycle t -> mc_busy=1 in cycles t+1..t+4 and mc_done=1 at t+4; id_src slot0=9 (valid) -> stall=1, stall_cause=10 in t+1..t+4 and 0 at t+5.
REQ-027 Scenario: second mc_issue held from t+1 -> stall_cause=11 in t+1..t+3; accepted at t+4 with mc_busy continuous through t+8.
REQ-028 Scenario: rst=1 at t+2 mid-operation -> from t+3 mc_busy=0, stall_cnt=0, and no mc_done.
REQ-029 Scenario: all hazard inputs reference register 0, or CNT_W=2 with 5 stalled cycles -> no stall, en_f=0 in the first case; stall_cnt holds at 3 in the second.
